// File: rtl/mat_maven_pkg.sv
// Shared constants for the matrix accelerator result framer.
// Frame length grows by one checksum byte under MAT_RESULT_TX_CHECKSUM_EN.
package mat_maven_pkg;

  localparam logic [7:0] MAT_HEADER = 8'hFF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] IDX_HDR = 3'd0;
  localparam logic [2:0] IDX_ID  = 3'd1;
  localparam logic [2:0] IDX_C11 = 3'd2;
  localparam logic [2:0] IDX_C12 = 3'd3;
  localparam logic [2:0] IDX_C21 = 3'd4;
  localparam logic [2:0] IDX_C22 = 3'd5;

`ifdef MAT_RESULT_TX_CHECKSUM_EN
  localparam logic [2:0] IDX_CSUM = 3'd6;
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  localparam logic [2:0] IDX_LAST = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/mat_result_tx_if.sv
// Job intake and UART byte handshake bundle for mat_result_tx.
// slave = framer, master = compute side plus UART transmitter.
interface mat_result_tx_if;

  logic       job_valid;
  logic       job_ready;
  logic [7:0] job_id;
  logic [7:0] c11;
  logic [7:0] c12;
  logic [7:0] c21;
  logic [7:0] c22;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_done;

  modport master (
    output job_valid, job_id,
    output c11, c12, c21, c22,
    output tx_ready,
    input  job_ready, tx_data,
    input  tx_valid, frame_done
  );

  modport slave (
    input  job_valid, job_id,
    input  c11, c12, c21, c22,
    input  tx_ready,
    output job_ready, tx_data,
    output tx_valid, frame_done
  );

endinterface

// File: rtl/mat_result_tx.sv
// Serializes a 2x2 result matrix as FF, id, c11, c12, c21, c22 bytes.
// MAT_RESULT_TX_CHECKSUM_EN appends an XOR checksum byte.
module mat_result_tx
  import mat_maven_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = MAT_HEADER,
  parameter int         GAP_CYCLES  = 0
) (
  input  logic           clk,
  input  logic           rst,
  mat_result_tx_if.slave bus
);

  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);

  logic [1:0]  state;
  logic [2:0]  idx;
  logic [15:0] gap_cnt;
  logic [7:0]  r_id;
  logic [7:0]  r_c11;
  logic [7:0]  r_c12;
  logic [7:0]  r_c21;
  logic [7:0]  r_c22;
  logic [7:0]  byte_sel;
  logic        last;

`ifdef MAT_RESULT_TX_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= 8'h00;
    end else if (state == S_IDLE && bus.job_valid) begin
      r_csum <= bus.job_id ^ bus.c11 ^ bus.c12
              ^ bus.c21 ^ bus.c22;
    end
  end
`endif

  assign last = (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      gap_cnt <= 16'd0;
      r_id    <= 8'h00;
      r_c11   <= 8'h00;
      r_c12   <= 8'h00;
      r_c21   <= 8'h00;
      r_c22   <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.job_valid) begin
            r_id  <= bus.job_id;
            r_c11 <= bus.c11;
            r_c12 <= bus.c12;
            r_c21 <= bus.c21;
            r_c22 <= bus.c22;
            idx   <= 3'd0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              idx <= idx + 3'd1;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LD;
                state   <= S_GAP;
              end
            end
          end
        end
        // Counter reaching 1 marks the final idle cycle.
        S_GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt == 16'd1) begin
            state <= S_SEND;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (1'b1)
      idx == IDX_HDR:  byte_sel = HEADER_BYTE;
      idx == IDX_ID:   byte_sel = r_id;
      idx == IDX_C11:  byte_sel = r_c11;
      idx == IDX_C12:  byte_sel = r_c12;
      idx == IDX_C21:  byte_sel = r_c21;
      idx == IDX_C22:  byte_sel = r_c22;
`ifdef MAT_RESULT_TX_CHECKSUM_EN
      idx == IDX_CSUM: byte_sel = r_csum;
`endif
      default:         byte_sel = 8'h00;
    endcase
  end

  // Outputs decode registered state only, so tx_ready never
  // reaches tx_valid and reset clears them immediately.
  assign bus.tx_valid   = (state == S_SEND);
  assign bus.tx_data    = (state == S_SEND) ? byte_sel : 8'h00;
  assign bus.job_ready  = (state == S_IDLE);
  assign bus.frame_done = (state == S_DONE);

endmodule

// File: tb/tb_mat_result_tx.sv
// Bench for mat_result_tx: GAP_CYCLES=0 and GAP_CYCLES=3 instances
// against a frame-queue model, plus literal frame/latency checks.
module tb_mat_result_tx;
  import mat_maven_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       job_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] job_id = 8'h00;
  logic [7:0] c11 = 8'h00;
  logic [7:0] c12 = 8'h00;
  logic [7:0] c21 = 8'h00;
  logic [7:0] c22 = 8'h00;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mat_result_tx_if bus0();
  mat_result_tx_if bus3();

  assign bus0.job_valid = job_valid;
  assign bus0.job_id    = job_id;
  assign bus0.c11       = c11;
  assign bus0.c12       = c12;
  assign bus0.c21       = c21;
  assign bus0.c22       = c22;
  assign bus0.tx_ready  = tx_ready;
  assign bus3.job_valid = job_valid;
  assign bus3.job_id    = job_id;
  assign bus3.c11       = c11;
  assign bus3.c12       = c12;
  assign bus3.c21       = c21;
  assign bus3.c22       = c22;
  assign bus3.tx_ready  = tx_ready;

  mat_result_tx #(.GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  mat_result_tx #(.GAP_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       jr [2];
  logic       tv [2];
  logic       fd [2];
  logic [7:0] td [2];

  assign jr[0] = bus0.job_ready;
  assign tv[0] = bus0.tx_valid;
  assign fd[0] = bus0.frame_done;
  assign td[0] = bus0.tx_data;
  assign jr[1] = bus3.job_ready;
  assign tv[1] = bus3.tx_valid;
  assign fd[1] = bus3.frame_done;
  assign td[1] = bus3.tx_data;

  // Model: each instance holds its pending frame as a byte list.
  bit         busy [2];
  bit         dd [2];
  int         rd [2];
  int         len [2];
  int         wt [2];
  int         acc_e [2];
  int         done_c [2];
  logic [7:0] fb [2][8];
  logic [7:0] lg [16];
  int         lg_n = 0;
  bit         er;
  bit         ev;

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h expected %0h",
               nm, inst, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk("rst_job_ready", i, 32'(jr[i]), 32'd1);
        chk("rst_tx_valid", i, 32'(tv[i]), 32'd0);
        chk("rst_tx_data", i, 32'(td[i]), 32'd0);
        chk("rst_frame_done", i, 32'(fd[i]), 32'd0);
        busy[i] = 1'b0;
        dd[i]   = 1'b0;
        rd[i]   = 0;
        len[i]  = 0;
        wt[i]   = 0;
      end else begin
        er = !busy[i];
        ev = busy[i] && !dd[i] && rd[i] < len[i] && wt[i] == 0;
        chk("job_ready", i, 32'(jr[i]), 32'(er));
        chk("frame_done", i, 32'(fd[i]), 32'(dd[i]));
        chk("tx_valid", i, 32'(tv[i]), 32'(ev));
        if (ev) chk("tx_data", i, 32'(td[i]), 32'(fb[i][rd[i]]));
        if (fd[i]) done_c[i] = cyc;
        if (dd[i]) begin
          dd[i]   = 1'b0;
          busy[i] = 1'b0;
        end else if (ev) begin
          if (tx_ready) begin
            if (i == 0 && lg_n < 16) begin
              lg[lg_n] = td[i];
              lg_n++;
            end
            rd[i]++;
            if (rd[i] == len[i]) dd[i] = 1'b1;
            else wt[i] = (i == 1) ? 3 : 0;
          end
        end else if (busy[i] && wt[i] > 0) begin
          wt[i]--;
        end
        if (er && job_valid) begin
          busy[i]  = 1'b1;
          rd[i]    = 0;
          wt[i]    = 0;
          len[i]   = FRAME_LEN;
          acc_e[i] = cyc + 1;
          fb[i][0] = 8'hFF;
          fb[i][1] = job_id;
          fb[i][2] = c11;
          fb[i][3] = c12;
          fb[i][4] = c21;
          fb[i][5] = c22;
          fb[i][6] = job_id ^ c11 ^ c12 ^ c21 ^ c22;
        end
      end
    end
  end

  task automatic send(input logic [7:0] id, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d);
    int k = 0;
    while (!(bus0.job_ready && bus3.job_ready) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 400) chk("idle_timeout", 0, 32'd1, 32'd0);
    lg_n = 0;
    job_id = id; c11 = a; c12 = b; c21 = c; c22 = d;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_id = 8'h5A; c11 = 8'hA5; c12 = 8'h3C;
    c21 = 8'hC3; c22 = 8'h0F;
  endtask

  logic [15:0] pat = 16'b1011_0010_0110_1001;

  task automatic run(input bit bp, input bit inj);
    int k = 0;
    do begin
      tx_ready = bp ? pat[k % 16] : 1'b1;
      job_valid = inj && k >= 1 && k <= 4;
      if (inj) job_id = 8'h09;
      @(posedge clk); #1;
      k++;
    end while (!(bus0.job_ready && bus3.job_ready) && k < 400);
    job_valid = 1'b0;
    tx_ready = 1'b1;
    if (k >= 400) chk("frame_timeout", 0, 32'd1, 32'd0);
  endtask

  task automatic check_log(input string nm, input logic [7:0] e [7]);
    chk({nm, "_len"}, 0, 32'(lg_n), 32'(FRAME_LEN));
    for (int j = 0; j < FRAME_LEN; j++)
      chk({nm, "_byte"}, j, 32'(lg[j]), 32'(e[j]));
  endtask

  logic [7:0] f_a [7] = '{8'hFF, 8'h05, 8'h13, 8'h16,
                          8'h2B, 8'h32, 8'h19};
  logic [7:0] f_b [7] = '{8'hFF, 8'h09, 8'h01, 8'h02,
                          8'h03, 8'h04, 8'h0D};
  logic [7:0] f_c [7] = '{8'hFF, 8'h77, 8'hFF, 8'h00,
                          8'hFF, 8'h80, 8'hF7};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
    run(1'b0, 1'b0);
    check_log("basic", f_a);
    chk("lat_gap0", 0, 32'(done_c[0] - acc_e[0]),
        32'(FRAME_LEN));
    chk("lat_gap3", 1, 32'(done_c[1] - acc_e[1]),
        32'(FRAME_LEN + 3 * (FRAME_LEN - 1)));

    send(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
    run(1'b1, 1'b0);
    check_log("backpressure", f_a);

    send(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
    run(1'b0, 1'b1);
    check_log("busy_ignore", f_a);

    send(8'h09, 8'h01, 8'h02, 8'h03, 8'h04);
    run(1'b0, 1'b0);
    check_log("second_job", f_b);

    send(8'h05, 8'h13, 8'h16, 8'h2B, 8'h32);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_bytes", 0, 32'(lg_n), 32'd3);
    chk("pre_rst_valid", 0, 32'(bus0.tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", 0, 32'(bus0.tx_valid), 32'd0);
    chk("async_done", 0, 32'(bus0.frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'h77, 8'hFF, 8'h00, 8'hFF, 8'h80);
    run(1'b1, 1'b0);
    check_log("after_rst", f_c);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
